// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if
//   Bundles the requester-side and engine-side signals of spi_bus_arbiter.
//   Packed [NREQ-1:0][7:0] tx_data puts requester i's byte at bits [8i+7:8i].
// Modports
//   slave  : arbiter view. It receives req/tx_* from clients and eng_done/eng_rx
//            from the engine, and drives grant, tx_ready, rx_*, cs_n, eng_* and err_spur.
//   master : client/engine view (the exact opposite of slave).
interface spi_bus_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0][7:0]  tx_data;
   logic [NREQ-1:0]       tx_valid;
   logic [NREQ-1:0]       tx_last;
   logic [NREQ-1:0]       tx_ready;
   logic [7:0]            rx_data;
   logic [NREQ-1:0]       rx_valid;
   logic [NREQ-1:0]       cs_n;
   logic                  eng_start;
   logic [7:0]            eng_tx;
   logic                  eng_done;
   logic [7:0]            eng_rx;
   logic                  err_spur;

   modport slave (
      input  req, tx_data, tx_valid, tx_last, eng_done, eng_rx,
      output grant, tx_ready, rx_data, rx_valid, cs_n, eng_start, eng_tx, err_spur
   );

   modport master (
      output req, tx_data, tx_valid, tx_last, eng_done, eng_rx,
      input  grant, tx_ready, rx_data, rx_valid, cs_n, eng_start, eng_tx, err_spur
   );
endinterface

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//   Shares one byte-level SPI engine between NREQ requesters.
//   Grants are round-robin, and each grant lasts a whole multi-byte transaction.
//   The arbiter drives the owner's chip select with setup, hold and idle-gap timing.
//   It hands bytes to the engine over a start/done handshake.
// Ports
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : spi_bus_arbiter_if.slave. This carries the requester handshake
//           (req/grant, tx_*, rx_*), the chip selects, the engine handshake
//           (eng_start/eng_tx/eng_done/eng_rx) and the sticky err_spur flag.
module spi_bus_arbiter #(
   parameter int NREQ     = 2,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int IDLE_GAP = 1
) (
   input  logic             clock,
   input  logic             reset,
   spi_bus_arbiter_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, HOLD, GAP} state_t;

   state_t          state;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   rr_next;
   logic [7:0]      cnt;
   logic            last_q;

   logic [NREQ-1:0] grant_q;
   logic [NREQ-1:0] cs_n_q;
   logic [NREQ-1:0] rx_valid_q;
   logic [7:0]      rx_data_q;
   logic            eng_start_q;
   logic [7:0]      eng_tx_q;
   logic            err_spur_q;

   logic [NREQ-1:0] tx_ready_c;
   logic            accept;
   logic [IW-1:0]   pick_idx;
   logic            pick_found;

   // The ready signal is combinational so that a byte is taken in the same cycle it is offered.
   // Non-owners are masked by grant_q, so their tx_ready stays 0.
   assign tx_ready_c = (state == XFER) ? (grant_q & bus.tx_valid) : '0;
   assign accept     = |tx_ready_c;

   assign rr_next = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

   // Find the first requester at or above rr_ptr, wrapping around to 0.
   always_comb begin
      int cand;
      cand       = 0;
      pick_idx   = '0;
      pick_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!pick_found && bus.req[IW'(cand)]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(cand);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
         last_q      <= 1'b0;
         grant_q     <= '0;
         cs_n_q      <= '1;
         rx_valid_q  <= '0;
         rx_data_q   <= '0;
         eng_start_q <= 1'b0;
         eng_tx_q    <= '0;
         err_spur_q  <= 1'b0;
      end else begin
         eng_start_q <= 1'b0;
         rx_valid_q  <= '0;
         // A done pulse arriving when no byte is in flight is only flagged.
         // It never produces data.
         if (bus.eng_done && state != WAIT) err_spur_q <= 1'b1;

         case (state)
            IDLE: begin
               if (pick_found) begin
                  owner   <= pick_idx;
                  grant_q <= ONE << pick_idx;
                  cs_n_q  <= ~(ONE << pick_idx);
                  cnt     <= '0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == 8'(CS_SETUP - 1)) begin
                  cnt   <= '0;
                  state <= XFER;
               end else cnt <= cnt + 8'd1;
            end
            XFER: begin
               if (accept) begin
                  eng_tx_q    <= bus.tx_data[owner];
                  last_q      <= bus.tx_last[owner];
                  eng_start_q <= 1'b1;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (bus.eng_done) begin
                  rx_data_q  <= bus.eng_rx;
                  rx_valid_q <= grant_q;
                  state      <= last_q ? HOLD : XFER;
               end
            end
            HOLD: begin
               if (cnt == 8'(CS_HOLD - 1)) begin
                  cnt     <= '0;
                  cs_n_q  <= '1;
                  grant_q <= '0;
                  rr_ptr  <= rr_next;
                  state   <= GAP;
               end else cnt <= cnt + 8'd1;
            end
            GAP: begin
               if (cnt == 8'(IDLE_GAP - 1)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else cnt <= cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.tx_ready  = tx_ready_c;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.cs_n      = cs_n_q;
   assign bus.eng_start = eng_start_q;
   assign bus.eng_tx    = eng_tx_q;
   assign bus.err_spur  = err_spur_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter
//   Directed bench for spi_bus_arbiter (NREQ=2, CS_SETUP=2, CS_HOLD=2, IDLE_GAP=1).
//   The bench plays both the requesters and the SPI engine through the interface.
module tb_spi_bus_arbiter;
   localparam int NREQ = 2, CS_SETUP = 2, CS_HOLD = 2, IDLE_GAP = 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   both_low = 0;
   int   cs0_breaks = 0;
   int   starts = 0;
   bit   watch0 = 1'b0;

   spi_bus_arbiter_if #(.NREQ(NREQ)) bus ();

   spi_bus_arbiter #(
      .NREQ(NREQ), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .IDLE_GAP(IDLE_GAP)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   // These background monitors sample on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (bus.cs_n == 2'b00) both_low <= both_low + 1;
      if (watch0 && bus.cs_n[0]) cs0_breaks <= cs0_breaks + 1;
      if (bus.eng_start) starts <= starts + 1;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_done(input logic [7:0] b);
      bus.eng_done = 1'b1;
      bus.eng_rx   = b;
      step();
      bus.eng_done = 1'b0;
      bus.eng_rx   = 8'h00;
   endtask

   // Offer one byte from requester idx. Wait (bounded) for the engine start, then answer with rxb.
   task automatic xfer_byte(input int idx, input logic [7:0] b, input logic [7:0] rxb,
                            input bit last, output bit ok);
      bus.tx_data[idx]  = b;
      bus.tx_last[idx]  = last;
      bus.tx_valid[idx] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         step();
         if (bus.eng_start) ok = 1'b1;
      end
      bus.tx_valid[idx] = 1'b0;
      bus.tx_last[idx]  = 1'b0;
      if (ok) pulse_done(rxb);
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         step();
         if (bus.grant != 2'b00) ok = 1'b1;
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         step();
         if (bus.grant == 2'b00) ok = 1'b1;
      end
      step();
   endtask

   task automatic test_reset();
      logic [25:0] obs;
      reset = 1'b1;
      step();
      step();
      obs = {bus.grant, bus.cs_n, bus.tx_ready, bus.rx_valid, bus.rx_data,
             bus.eng_start, bus.eng_tx, bus.err_spur};
      checks++;
      if (obs !== {2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got %h want %h", obs,
                  {2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0});
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      bus.req = 2'b01;
      bus.tx_data[0] = 8'hA5; bus.tx_last[0] = 1'b1; bus.tx_valid[0] = 1'b1;
      step();
      checks++;
      if ({bus.grant, bus.cs_n, bus.tx_ready} !== 6'b01_10_00) begin
         errors++;
         $display("FAIL single_grant: grant=%b cs_n=%b ready=%b want 01 10 00",
                  bus.grant, bus.cs_n, bus.tx_ready);
      end
      step();
      checks++;
      if (bus.tx_ready !== 2'b00) begin
         errors++; $display("FAIL single_setup_ready: got %b want 00", bus.tx_ready);
      end
      step();
      checks++;
      if (bus.tx_ready !== 2'b01) begin
         errors++; $display("FAIL single_xfer_ready: got %b want 01", bus.tx_ready);
      end
      step();
      checks++;
      if ({bus.eng_start, bus.eng_tx} !== {1'b1, 8'hA5}) begin
         errors++;
         $display("FAIL single_start: start=%b tx=%h want 1 a5", bus.eng_start, bus.eng_tx);
      end
      bus.tx_valid[0] = 1'b0; bus.tx_last[0] = 1'b0; bus.req = 2'b00;
      step();
      checks++;
      if (bus.eng_start !== 1'b0) begin
         errors++; $display("FAIL single_start_pulse: got %b want 0", bus.eng_start);
      end
      pulse_done(8'h3C);
      checks++;
      if ({bus.rx_valid, bus.rx_data, bus.cs_n} !== {2'b01, 8'h3C, 2'b10}) begin
         errors++;
         $display("FAIL single_rx: rxv=%b rxd=%h cs_n=%b want 01 3c 10",
                  bus.rx_valid, bus.rx_data, bus.cs_n);
      end
      step();
      checks++;
      if ({bus.rx_valid, bus.cs_n} !== {2'b00, 2'b10}) begin
         errors++;
         $display("FAIL single_hold: rxv=%b cs_n=%b want 00 10", bus.rx_valid, bus.cs_n);
      end
      step();
      checks++;
      if ({bus.cs_n, bus.grant} !== {2'b11, 2'b00}) begin
         errors++;
         $display("FAIL single_release: cs_n=%b grant=%b want 11 00", bus.cs_n, bus.grant);
      end
      step();
   endtask

   task automatic test_multi_byte();
      logic [7:0] txb [3] = '{8'h11, 8'h22, 8'h33};
      logic [7:0] rxb [3] = '{8'hE1, 8'hE2, 8'hE3};
      bit ok;
      int s0;
      bus.req = 2'b01;
      wait_grant(ok);
      checks++;
      if (!ok || bus.grant !== 2'b01) begin
         errors++; $display("FAIL multi_grant: got %b want 01", bus.grant);
      end
      watch0 = 1'b1;
      s0 = starts;
      for (int i = 0; i < 3; i++) begin
         xfer_byte(0, txb[i], rxb[i], i == 2, ok);
         checks++;
         if (!ok || bus.eng_tx !== txb[i] || bus.rx_valid !== 2'b01 || bus.rx_data !== rxb[i]) begin
            errors++;
            $display("FAIL multi_byte%0d: ok=%0d tx=%h rxv=%b rxd=%h want 1 %h 01 %h",
                     i, ok, bus.eng_tx, bus.rx_valid, bus.rx_data, txb[i], rxb[i]);
         end
      end
      watch0 = 1'b0;
      bus.req = 2'b00;
      checks++;
      if (starts - s0 != 3 || cs0_breaks != 0) begin
         errors++;
         $display("FAIL multi_starts_cs: starts=%0d breaks=%0d want 3 0", starts - s0, cs0_breaks);
      end
      wait_idle(ok);
   endtask

   task automatic test_round_robin();
      logic [1:0] expg [3] = '{2'b01, 2'b10, 2'b01};
      bit ok;
      int idx;
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.req = 2'b11;
      for (int i = 0; i < 3; i++) begin
         wait_grant(ok);
         checks++;
         if (!ok || bus.grant !== expg[i]) begin
            errors++; $display("FAIL rr_grant%0d: got %b want %b", i, bus.grant, expg[i]);
         end
         idx = (expg[i] == 2'b01) ? 0 : 1;
         xfer_byte(idx, 8'h40 + 8'(i), 8'h90 + 8'(i), 1'b1, ok);
         checks++;
         if (!ok || bus.rx_valid !== expg[i]) begin
            errors++;
            $display("FAIL rr_rx%0d: ok=%0d rxv=%b want 1 %b", i, ok, bus.rx_valid, expg[i]);
         end
         wait_idle(ok);
      end
      bus.req = 2'b00;
      checks++;
      if (both_low != 0) begin
         errors++; $display("FAIL rr_cs_exclusive: both-low cycles=%0d want 0", both_low);
      end
   endtask

   task automatic test_stall();
      bit ok;
      int s0;
      int bad;
      bus.req = 2'b01;
      wait_grant(ok);
      xfer_byte(0, 8'h5A, 8'hC3, 1'b0, ok);
      checks++;
      if (!ok || bus.rx_data !== 8'hC3) begin
         errors++; $display("FAIL stall_first: ok=%0d rxd=%h want 1 c3", ok, bus.rx_data);
      end
      s0  = starts;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.cs_n !== 2'b10) bad++;
      end
      checks++;
      if (starts != s0 || bad != 0) begin
         errors++;
         $display("FAIL stall_hold: starts=%0d cs_bad=%0d want 0 0", starts - s0, bad);
      end
      xfer_byte(0, 8'h6B, 8'hD4, 1'b1, ok);
      checks++;
      if (!ok || bus.eng_tx !== 8'h6B || bus.rx_data !== 8'hD4 || bus.rx_valid !== 2'b01) begin
         errors++;
         $display("FAIL stall_resume: ok=%0d tx=%h rxd=%h rxv=%b want 1 6b d4 01",
                  ok, bus.eng_tx, bus.rx_data, bus.rx_valid);
      end
      bus.req = 2'b00;
      wait_idle(ok);
   endtask

   task automatic test_spurious();
      step(); step(); step();
      checks++;
      if (bus.err_spur !== 1'b0) begin
         errors++; $display("FAIL spur_before: got %b want 0", bus.err_spur);
      end
      pulse_done(8'h77);
      checks++;
      if ({bus.err_spur, bus.rx_valid} !== 3'b1_00) begin
         errors++;
         $display("FAIL spur_flag: err=%b rxv=%b want 1 00", bus.err_spur, bus.rx_valid);
      end
      step(); step(); step();
      checks++;
      if ({bus.err_spur, bus.grant, bus.cs_n} !== 5'b1_00_11) begin
         errors++;
         $display("FAIL spur_sticky_idle: err=%b grant=%b cs_n=%b want 1 00 11",
                  bus.err_spur, bus.grant, bus.cs_n);
      end
   endtask

   task automatic test_reset_mid();
      logic [25:0] obs;
      bit ok;
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (bus.err_spur !== 1'b0) begin
         errors++; $display("FAIL mid_spur_clear: got %b want 0", bus.err_spur);
      end
      bus.req = 2'b01;
      bus.tx_data[0] = 8'h9C; bus.tx_last[0] = 1'b1; bus.tx_valid[0] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         step();
         if (bus.eng_start) ok = 1'b1;
      end
      bus.tx_valid[0] = 1'b0; bus.tx_last[0] = 1'b0;
      checks++;
      if (!ok || bus.cs_n !== 2'b10) begin
         errors++; $display("FAIL mid_in_wait: ok=%0d cs_n=%b want 1 10", ok, bus.cs_n);
      end
      reset = 1'b1;
      step();
      obs = {bus.grant, bus.cs_n, bus.tx_ready, bus.rx_valid, bus.rx_data,
             bus.eng_start, bus.eng_tx, bus.err_spur};
      checks++;
      if (obs !== {2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h want %h", obs,
                  {2'b00, 2'b11, 2'b00, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0});
      end
      reset = 1'b0;
      bus.req = 2'b00;
      pulse_done(8'h55);
      checks++;
      if ({bus.err_spur, bus.rx_valid} !== 3'b1_00) begin
         errors++;
         $display("FAIL mid_late_done: err=%b rxv=%b want 1 00", bus.err_spur, bus.rx_valid);
      end
   endtask

   initial begin
      bus.req      = '0;
      bus.tx_data  = '0;
      bus.tx_valid = '0;
      bus.tx_last  = '0;
      bus.eng_done = 1'b0;
      bus.eng_rx   = 8'h00;
      test_reset();
      test_single();
      test_multi_byte();
      test_round_robin();
      test_stall();
      test_spurious();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
